// File: rtl/tetris_song_pkg.sv
// Shared constants for the Tetris note sequencer: FSM state encodings,
// note ROM field positions and the tempo tick helper.
package tetris_song_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int unsigned END_BIT = 31;
    localparam int unsigned DUR_MSB = 30;
    localparam int unsigned DUR_LSB = 24;
    localparam int unsigned HP_MSB  = 23;
    localparam int unsigned HP_LSB  = 0;

    // Last tempo count before a tick; a divider of 0 behaves like 1.
    function automatic logic [31:0] tick_limit(input logic [31:0] div);
        return (div == '0) ? '0 : div - 32'd1;
    endfunction

endpackage

// File: rtl/tetris_note_sequencer_tone_pwm_gen.sv
// Square-wave tone generator (half-period counter) followed by a free-running
// PWM comparator that scales the tone by the volume register.
module tone_pwm_gen #(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [23:0]      half_period,
    input  logic [PWM_W-1:0] volume,
    output logic             audio_pwm
);

    logic [23:0]      hp_cnt;
    logic             tone;
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_cnt    <= '0;
            tone      <= 1'b0;
            pwm_cnt   <= '0;
            audio_pwm <= 1'b0;
        end else if (clear) begin
            hp_cnt    <= '0;
            tone      <= 1'b0;
            pwm_cnt   <= '0;
            audio_pwm <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            audio_pwm <= enable & tone & (pwm_cnt < volume);
            // Disabled or rest: hold phase at zero so the next note starts low.
            if (!enable || half_period == '0) begin
                hp_cnt <= '0;
                tone   <= 1'b0;
            end else if (hp_cnt == half_period - 24'd1) begin
                hp_cnt <= '0;
                tone   <= ~tone;
            end else begin
                hp_cnt <= hp_cnt + 24'd1;
            end
        end
    end

endmodule

// File: rtl/tetris_note_sequencer.sv
// Song playback engine: walks the note ROM, times each note with the tempo
// divider and drives the PWM audio pin through tone_pwm_gen.
module tetris_note_sequencer
    import tetris_song_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned PWM_W      = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              ctrl_play,
    input  logic              ctrl_loop,
    input  logic [31:0]       tempo_div,
    input  logic [PWM_W-1:0]  volume,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              audio_pwm,
    output logic              audio_sd,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              song_done
);

    logic [2:0]  state;
    logic [6:0]  dur_cnt;
    logic [23:0] half_period;
    logic [31:0] tempo_cnt;
    logic [31:0] gap_cnt;
    logic        active;
    logic        stop;
    logic        tick;
    logic [6:0]  rom_dur;

    assign active    = (state == ST_FETCH) || (state == ST_WAIT) ||
                       (state == ST_PLAY)  || (state == ST_GAP);
    assign stop      = active && !ctrl_play;
    assign busy      = active;
    assign audio_sd  = active;
    assign rom_dur   = rom_data[DUR_MSB:DUR_LSB];
    // >= rather than == so lowering tempo_div mid-note cannot skip past the tick.
    assign tick      = (tempo_cnt >= tick_limit(tempo_div));
    assign song_done = (state == ST_WAIT) && ctrl_play &&
                       rom_data[END_BIT] && !ctrl_loop;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= ST_IDLE;
            rom_addr    <= '0;
            note_idx    <= '0;
            dur_cnt     <= '0;
            half_period <= '0;
            tempo_cnt   <= '0;
            gap_cnt     <= '0;
        end else if (stop) begin
            state     <= ST_IDLE;
            rom_addr  <= '0;
            note_idx  <= '0;
            dur_cnt   <= '0;
            tempo_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_play) begin
                        state    <= ST_FETCH;
                        rom_addr <= '0;
                    end
                end
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    if (rom_data[END_BIT]) begin
                        if (ctrl_loop) begin
                            rom_addr <= '0;
                            state    <= ST_FETCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        dur_cnt     <= (rom_dur == '0) ? 7'd1 : rom_dur;
                        half_period <= rom_data[HP_MSB:HP_LSB];
                        note_idx    <= rom_addr;
                        tempo_cnt   <= '0;
                        state       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        tempo_cnt <= '0;
                        if (dur_cnt <= 7'd1) begin
                            rom_addr <= rom_addr + 1'b1;
                            gap_cnt  <= '0;
                            state    <= (GAP_CYCLES == 0) ? ST_FETCH : ST_GAP;
                        end else begin
                            dur_cnt <= dur_cnt - 7'd1;
                        end
                    end else begin
                        tempo_cnt <= tempo_cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 32'(GAP_CYCLES - 1)) begin
                        state <= ST_FETCH;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    if (!ctrl_play) begin
                        state    <= ST_IDLE;
                        rom_addr <= '0;
                        note_idx <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    tone_pwm_gen #(
        .PWM_W (PWM_W)
    ) u_tone_pwm_gen (
        .clk         (ACLK),
        .rst         (ARESET),
        .enable      (state == ST_PLAY),
        .clear       (stop || (state == ST_IDLE)),
        .half_period (half_period),
        .volume      (volume),
        .audio_pwm   (audio_pwm)
    );

endmodule

// File: tb/tb_tetris_note_sequencer.sv
// Directed bench for tetris_note_sequencer: two instances (no gap / 4-cycle gap)
// share the control inputs and a behavioural synchronous note ROM.
module tb_tetris_note_sequencer;

    logic        clk = 1'b0;
    logic        ARESET;
    logic        ctrl_play;
    logic        ctrl_loop;
    logic [31:0] tempo_div;
    logic [7:0]  volume;

    logic [7:0]  rom_addr,  rom_addr_g;
    logic [31:0] rom_data,  rom_data_g;
    logic        audio_pwm, audio_pwm_g;
    logic        audio_sd,  audio_sd_g;
    logic        busy,      busy_g;
    logic [7:0]  note_idx,  note_idx_g;
    logic        song_done, song_done_g;

    logic [31:0] rom [0:255];

    int tests  = 0;
    int failed = 0;

    int done_at, done_cnt, hi_cnt, busy_cnt, sd_bad, nidx_nz;
    int done_at_g, done_cnt_g, hi_cnt_g, busy_cnt_g;
    logic [7:0] addr_log   [0:127];
    logic [7:0] addr_log_g [0:127];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data   <= rom[rom_addr];
        rom_data_g <= rom[rom_addr_g];
    end

    tetris_note_sequencer #(
        .ADDR_W     (8),
        .GAP_CYCLES (0),
        .PWM_W      (8)
    ) dut (
        .ACLK      (clk),
        .ARESET    (ARESET),
        .ctrl_play (ctrl_play),
        .ctrl_loop (ctrl_loop),
        .tempo_div (tempo_div),
        .volume    (volume),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .audio_pwm (audio_pwm),
        .audio_sd  (audio_sd),
        .busy      (busy),
        .note_idx  (note_idx),
        .song_done (song_done)
    );

    tetris_note_sequencer #(
        .ADDR_W     (8),
        .GAP_CYCLES (4),
        .PWM_W      (8)
    ) dut_g (
        .ACLK      (clk),
        .ARESET    (ARESET),
        .ctrl_play (ctrl_play),
        .ctrl_loop (ctrl_loop),
        .tempo_div (tempo_div),
        .volume    (volume),
        .rom_addr  (rom_addr_g),
        .rom_data  (rom_data_g),
        .audio_pwm (audio_pwm_g),
        .audio_sd  (audio_sd_g),
        .busy      (busy_g),
        .note_idx  (note_idx_g),
        .song_done (song_done_g)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises ctrl_play and gathers per-cycle statistics for n cycles.
    task automatic run(input int n);
        done_at = -1; done_cnt = 0; hi_cnt = 0; busy_cnt = 0; sd_bad = 0; nidx_nz = 0;
        done_at_g = -1; done_cnt_g = 0; hi_cnt_g = 0; busy_cnt_g = 0;
        ctrl_play = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (song_done)   begin done_cnt++;   if (done_at < 0)   done_at = i;   end
            if (song_done_g) begin done_cnt_g++; if (done_at_g < 0) done_at_g = i; end
            hi_cnt     += int'(audio_pwm);
            hi_cnt_g   += int'(audio_pwm_g);
            busy_cnt   += int'(busy);
            busy_cnt_g += int'(busy_g);
            if (audio_sd !== busy || audio_sd_g !== busy_g) sd_bad++;
            if (note_idx !== 8'd0) nidx_nz++;
            if (i < 128) begin
                addr_log[i]   = rom_addr;
                addr_log_g[i] = rom_addr_g;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int trans;
        int win;
        ARESET = 1'b1; ctrl_play = 1'b0; ctrl_loop = 1'b0;
        tempo_div = 32'd10; volume = 8'd255;
        for (int i = 0; i < 256; i++) rom[i] = 32'h8000_0000;
        rom[0] = {1'b0, 7'd2, 24'd4};
        rom[1] = 32'h8000_0000;

        repeat (3) tick();
        check("rst_busy",     busy,      0);
        check("rst_sd",       audio_sd,  0);
        check("rst_pwm",      audio_pwm, 0);
        check("rst_addr",     rom_addr,  0);
        check("rst_note_idx", note_idx,  0);
        check("rst_done",     song_done, 0);
        ARESET = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // One note hp=4 dur=2 at tempo 10, then end marker
        run(40);
        check("play_start_addr", addr_log[0], 0);
        check("done_at",         done_at,     23);
        check("done_pulses",     done_cnt,    1);
        check("pwm_hi_cycles",   hi_cnt,      8);
        check("busy_cycles",     busy_cnt,    24);
        check("sd_eq_busy",      sd_bad,      0);
        check("addr_after_note", addr_log[22], 1);
        check("g_addr_pre_gap",  addr_log_g[21], 0);
        check("g_addr_in_gap",   addr_log_g[22], 1);
        check("g_done_at",       done_at_g,   27);
        check("g_done_pulses",   done_cnt_g,  1);
        check("g_pwm_hi_cycles", hi_cnt_g,    8);
        check("g_busy_cycles",   busy_cnt_g,  28);
        check("done_hold_busy",  busy,        0);
        check("done_hold_sd",    audio_sd,    0);
        check("done_hold_addr",  rom_addr,    1);
        ctrl_play = 1'b0;
        tick();
        check("done_to_idle_addr", rom_addr, 0);
        check("done_to_idle_busy", busy,     0);

        // Loop mode: address alternates 0,1 with no song_done
        ctrl_loop = 1'b1;
        run(100);
        check("loop_done",      done_cnt,   0);
        check("loop_done_g",    done_cnt_g, 0);
        check("loop_note_idx",  nidx_nz,    0);
        check("loop_busy",      busy_cnt,   100);
        check("loop_addr22",    addr_log[22], 1);
        check("loop_addr23",    addr_log[23], 1);
        check("loop_addr24",    addr_log[24], 0);
        trans = 0;
        for (int i = 1; i < 100; i++)
            if (addr_log[i-1] == 8'd1 && addr_log[i] == 8'd0) trans++;
        check("loop_wraps", trans, 4);

        // Stop mid-note (dut is in PLAY here)
        ctrl_play = 1'b0;
        tick();
        check("stop_busy",     busy,      0);
        check("stop_sd",       audio_sd,  0);
        check("stop_addr",     rom_addr,  0);
        check("stop_note_idx", note_idx,  0);
        check("stop_pwm",      audio_pwm, 0);

        // Re-raise restarts from address 0
        ctrl_loop = 1'b0;
        run(30);
        check("restart_addr0",   addr_log[0], 0);
        check("restart_done_at", done_at,     23);
        ctrl_play = 1'b0;
        tick();

        // Reset asserted during the second note
        rom[1] = {1'b0, 7'd2, 24'd4};
        rom[2] = 32'h8000_0000;
        run(30);
        check("pre_rst_note_idx", note_idx, 1);
        check("pre_rst_addr",     rom_addr, 1);
        ARESET = 1'b1;
        ctrl_play = 1'b0;
        #1;
        check("async_rst_busy",     busy,     0);
        check("async_rst_addr",     rom_addr, 0);
        check("async_rst_note_idx", note_idx, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("in_rst_outputs",
                  {26'd0, busy, audio_sd, audio_pwm, song_done, |rom_addr, |note_idx}, 0);
        end
        ARESET = 1'b0;
        win = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            win += int'(busy) + int'(song_done);
        end
        check("post_rst_idle", win, 0);

        // Rest note hp=0 dur=3 with tempo_div=0
        rom[0] = {1'b0, 7'd3, 24'd0};
        rom[1] = 32'h8000_0000;
        tempo_div = 32'd0;
        run(12);
        check("rest_pwm",     hi_cnt,     0);
        check("rest_done_at", done_at,    6);
        check("rest_busy",    busy_cnt,   7);
        check("rest_sd",      sd_bad,     0);
        check("rest_g_done",  done_at_g,  10);
        check("rest_g_busy",  busy_cnt_g, 11);
        ctrl_play = 1'b0;
        tick();

        // Volume scaling on a long tone (hp=1000)
        rom[0] = {1'b0, 7'd127, 24'd1000};
        tempo_div = 32'd100;
        volume = 8'd64;
        ctrl_play = 1'b1;
        hi_cnt = 0; done_cnt = 0; busy_cnt = 0; trans = 0; win = 0;
        for (int i = 0; i < 2400; i++) begin
            tick();
            if (i >= 1200 && i < 1456) hi_cnt++;
            if (i >= 1200 && i < 1456) busy_cnt += int'(audio_pwm);
            if (i >= 1462 && i < 1718) done_cnt += int'(audio_pwm);
            if (i >= 1722 && i < 1978) trans += int'(audio_pwm);
            if (i >= 2100 && i < 2356) win += int'(audio_pwm);
            if (i == 1460) volume = 8'd0;
            if (i == 1720) volume = 8'd255;
        end
        check("vol_window_len", hi_cnt,   256);
        check("vol64_duty",     busy_cnt, 64);
        check("vol0_duty",      done_cnt, 0);
        check("vol255_duty",    trans,    255);
        check("tone_low_duty",  win,      0);
        ctrl_play = 1'b0;
        tick();
        check("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
